qea_host_sequencer: RTL and testbench
=====================================

Name: qea_host_sequencer

Overview:
- Host-side sequencer directly upstream of QEA; replaces the bench-driven load/run/readout sequence with RTL.
- Accepts a job config plus a gate-context stream and writes the context into QEA's context RAM.
- Initialises QEA's state RAM to |0>, pulses QEA start and times the run.
- Streams the final state vector out over a valid/ready result port.

Parameters:
- PE_NUM, 4, number of PEs (state words per address)
- DATA_WIDTH, 32, real/imag component width
- MAX_QBIT_WIDTH, 6, width of qubit-count field
- STATE_ADDR_WIDTH, 16, QEA state RAM address width
- GATE_CONTEXT_ADDR_WIDTH, 16, QEA context RAM address width
- NUM_FRAC_BIT, 30, fixed-point fraction bits (amplitude 1.0 = 1<<NUM_FRAC_BIT)
- STATE_RD_LATENCY, 1, cycles from state read address to valid i_qea_state_dout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_cfg_valid / o_cfg_ready  in/out  1  job config handshake
- i_cfg_qbit_num  in  MAX_QBIT_WIDTH  qubit count n
- i_cfg_ins_num  in  GATE_CONTEXT_ADDR_WIDTH+1  context word count
- i_ctx_valid / o_ctx_ready  in/out  1  context stream handshake
- i_ctx_data  in  2*DATA_WIDTH  context word
- o_qea_start  out  1  one-cycle start pulse to QEA
- o_qea_qbit_num  out  MAX_QBIT_WIDTH  latched n
- o_qea_ctx_en, o_qea_ctx_wea  out  1  context RAM enable/write
- o_qea_ctx_addr  out  GATE_CONTEXT_ADDR_WIDTH  context address
- o_qea_ctx_data  out  2*DATA_WIDTH  context write data
- o_qea_state_ena, o_qea_state_wea  out  1  state RAM enable/write
- o_qea_state_addra  out  STATE_ADDR_WIDTH  state address
- o_qea_state_dina  out  PE_NUM*2*DATA_WIDTH  state write data
- i_qea_complete  in  1  QEA completion level
- i_qea_state_dout  in  PE_NUM*2*DATA_WIDTH  state read data
- o_res_valid / i_res_ready  out/in  1  result stream handshake
- o_res_data  out  PE_NUM*2*DATA_WIDTH  state word
- o_res_last  out  1  final result word
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse after last result accepted
- o_err  out  1  sticky config error; cleared by next accepted valid config
- o_exec_cycles  out  32  cycles from start pulse to complete observed, saturating

Behaviour:
- Reset: all outputs 0, FSM IDLE. Reset mid-job aborts immediately; no partial writes continue.
- IDLE: o_cfg_ready=1.
  - Valid config needs 3 <= n <= STATE_ADDR_WIDTH+2 and ins_num <= 2^GATE_CONTEXT_ADDR_WIDTH.
  - Invalid config: set o_err, stay IDLE.
  - Valid config: latch n and ins_num, clear o_err, raise o_busy. Go to LOAD_CTX, or to INIT_STATE if ins_num=0.
- LOAD_CTX: o_ctx_ready=1.
  - Each accepted word drives ctx_en=wea=1, addr=k (k from 0), data=i_ctx_data in the same cycle, combinationally from the handshake.
  - After word ins_num-1, go to INIT_STATE.
  - Stalls on i_ctx_valid=0 hold en/wea low.
- INIT_STATE: write addresses 0..2^(n-2)-1, one per cycle, ena=wea=1.
  - Address 0 dina: bits [PE_NUM*2*DATA_WIDTH-1 -: DATA_WIDTH] = 1<<NUM_FRAC_BIT; all other bits 0.
  - All other addresses: dina=0.
- START: o_qea_start=1 for exactly one cycle; clear exec counter.
- RUN: counter increments each cycle. i_qea_complete is ignored in the first RUN cycle (stale level); sampled from the second cycle on. Complete seen -> freeze o_exec_cycles, go to READ.
- READ: per address a = 0..2^(n-2)-1:
  - Drive ena=1, wea=0, addra=a for one cycle.
  - Wait STATE_RD_LATENCY cycles, capture i_qea_state_dout into a hold register, assert o_res_valid.
  - Hold data stable until i_res_ready; then issue the next address.
  - o_res_last=1 on word 2^(n-2)-1.
- DONE: o_done pulse one cycle, o_busy=0, return to IDLE.
- Config during busy is not accepted (o_cfg_ready=0).
- Counter saturates at 2^32-1; ctx address never wraps because ins_num is bounded.

Decomposition:
- Shared package qea_pkg: FSM state enum, AMP_ONE constant, state word width, ctx word width.
- One sub-module, qea_readout_buf: read-issue/latency-delay/hold register with valid/ready. Handles backpressure; isolates STATE_RD_LATENCY.

Test Plan:
- n=10, ins_num=501, ctx stream without gaps -> 501 ctx writes at addr 0..500 matching data; 256 state writes; addr 0 top slot = 0x40000000_00000000, others 0; one start pulse.
- Ctx stream with random i_ctx_valid gaps -> same write sequence, no duplicate or skipped addresses.
- QEA model raises complete 1000 cycles after start -> o_exec_cycles = 1000 ±1 (documented exact value); 256 result words in order, last flagged on word 255, o_done one cycle later.
- i_res_ready toggled randomly during readout -> o_res_data stable while valid && !ready; no word lost.
- Config n=2, then n=19 -> o_err=1, no QEA activity; then valid config n=3 -> o_err cleared, 2 state words written.
- rst asserted during INIT_STATE -> all outputs 0 next edge; new job afterwards runs cleanly.

Source files
------------

// File: rtl/qea_pkg.sv
// Shared definitions for the QEA host sequencer.
//   - sequencer FSM state encoding
//   - default word geometry (PE count, component width, fraction bits)
//   - AMP_ONE: fixed-point amplitude 1.0 at the default geometry
package qea_pkg;

    localparam int QEA_PE_NUM       = 4;
    localparam int QEA_DATA_WIDTH   = 32;
    localparam int QEA_NUM_FRAC_BIT = 30;

    // One context word is a complex pair; one state word holds PE_NUM pairs.
    localparam int CTX_WORD_W   = 2 * QEA_DATA_WIDTH;
    localparam int STATE_WORD_W = QEA_PE_NUM * CTX_WORD_W;

    localparam logic [QEA_DATA_WIDTH-1:0] AMP_ONE =
        QEA_DATA_WIDTH'(1) << QEA_NUM_FRAC_BIT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CTX,
        ST_INIT_STATE,
        ST_START,
        ST_RUN,
        ST_READ,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/qea_readout_buf.sv
// Final-state readout engine.
// Walks state RAM addresses 0..last_addr_i, one read per word. Each read is
// issued for one cycle, the RAM data is captured STATE_RD_LATENCY cycles later
// into a hold register and presented on a valid/ready port. The next address
// is only issued after the held word is accepted, so backpressure never drops
// or overwrites data.
// Ports:
//   clk, rst        clock, async active-high reset
//   start_i         one-cycle pulse: begin readout at address 0
//   last_addr_i     final address of this job (stable while active)
//   ena_o, addra_o  state RAM read strobe / address
//   dout_i          state RAM read data
//   res_*           result stream (valid/ready, data, last)
//   done_o          pulse in the cycle the final word is accepted
module qea_readout_buf
    import qea_pkg::*;
#(
    parameter int ADDR_W           = 16,
    parameter int WORD_W           = STATE_WORD_W,
    parameter int STATE_RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    output logic              ena_o,
    output logic [ADDR_W-1:0] addra_o,
    input  logic [WORD_W-1:0] dout_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [WORD_W-1:0] res_data_o,
    output logic              res_last_o,
    output logic              done_o
);

    localparam int LAT = STATE_RD_LATENCY;

    logic              active_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LAT-1:0]    pipe_q;
    logic              valid_q;
    logic [WORD_W-1:0] hold_q;

    logic issue;
    logic accept;
    logic last_word;

    // At most one read in flight: issue only when nothing is in the delay
    // line and the hold register is empty.
    assign issue     = active_q && !valid_q && (pipe_q == '0);
    assign accept    = valid_q && res_ready_i;
    assign last_word = (addr_q == last_addr_i);

    assign ena_o       = issue;
    assign addra_o     = issue ? addr_q : '0;
    assign res_valid_o = valid_q;
    assign res_data_o  = hold_q;
    assign res_last_o  = valid_q && last_word;
    assign done_o      = accept && last_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            addr_q   <= '0;
            pipe_q   <= '0;
            valid_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            pipe_q <= (pipe_q << 1) | LAT'(issue);
            if (start_i) begin
                active_q <= 1'b1;
                addr_q   <= '0;
            end
            if (pipe_q[LAT-1]) begin
                hold_q  <= dout_i;
                valid_q <= 1'b1;
            end
            if (accept) begin
                valid_q <= 1'b0;
                if (last_word) begin
                    active_q <= 1'b0;
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/qea_host_sequencer.sv
// Host-side job sequencer for QEA: loads gate context, initialises the state
// RAM to |0>, starts and times the run, then streams the final state out.
// Ports:
//   clk, rst                        clock, async active-high reset
//   i_cfg_* / o_cfg_ready           job config (qubit count, context length)
//   i_ctx_* / o_ctx_ready           context word stream
//   o_qea_start, o_qea_qbit_num     run control to QEA
//   o_qea_ctx_*                     QEA context RAM write port
//   o_qea_state_*, i_qea_state_dout QEA state RAM port (init writes, readout)
//   i_qea_complete                  QEA completion level
//   o_res_*                         result stream (valid/ready, data, last)
//   o_busy, o_done, o_err           job status; o_err is sticky
//   o_exec_cycles                   run length in cycles, saturating
//
// state      | meaning
// IDLE       | waiting for a job config
// LOAD_CTX   | writing streamed context words to context RAM
// INIT_STATE | writing |0> into state RAM, one word per cycle
// START      | one-cycle start pulse, exec counter cleared
// RUN        | counting until QEA reports complete
// READ       | readout engine streams the state vector
// DONE       | one-cycle done pulse
module qea_host_sequencer
    import qea_pkg::*;
#(
    parameter int PE_NUM                  = QEA_PE_NUM,
    parameter int DATA_WIDTH              = QEA_DATA_WIDTH,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = QEA_NUM_FRAC_BIT,
    parameter int STATE_RD_LATENCY        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_cfg_valid,
    output logic                                 o_cfg_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cfg_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cfg_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [2*DATA_WIDTH-1:0]              i_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
    output logic                                 o_qea_ctx_en,
    output logic                                 o_qea_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_qea_ctx_addr,
    output logic [2*DATA_WIDTH-1:0]              o_qea_ctx_data,
    output logic                                 o_qea_state_ena,
    output logic                                 o_qea_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_qea_state_addra,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_qea_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0]       i_qea_state_dout,
    output logic                                 o_res_valid,
    input  logic                                 i_res_ready,
    output logic [PE_NUM*2*DATA_WIDTH-1:0]       o_res_data,
    output logic                                 o_res_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_exec_cycles
);

    localparam int STATE_W = PE_NUM * 2 * DATA_WIDTH;
    localparam int KW      = GATE_CONTEXT_ADDR_WIDTH + 1;
    localparam int AW      = STATE_ADDR_WIDTH;

    localparam logic [KW-1:0]         MAX_INS = KW'(1) << GATE_CONTEXT_ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] AMP     = DATA_WIDTH'(1) << NUM_FRAC_BIT;

    seq_state_e                state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0] qbit_q, qbit_d;
    logic [KW-1:0]             ins_q, ins_d;
    logic [KW-1:0]             k_q, k_d;
    logic [AW-1:0]             a_q, a_d;
    logic [31:0]               cnt_q, cnt_d;
    logic                      first_q, first_d;
    logic                      err_q, err_d;
    logic                      cfg_ready_q;

    logic          cfg_ok;
    logic [AW:0]   depth;
    logic [AW-1:0] last_addr;
    logic          rd_start;
    logic          rd_ena;
    logic [AW-1:0] rd_addr;
    logic          rd_done;

    assign cfg_ok = (i_cfg_qbit_num >= MAX_QBIT_WIDTH'(3))
                 && (i_cfg_qbit_num <= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + 2))
                 && (i_cfg_ins_num <= MAX_INS);

    // Each address carries PE_NUM amplitudes, so a job spans 2^(n-2) words.
    assign depth     = (AW + 1)'(1) << (qbit_q - MAX_QBIT_WIDTH'(2));
    assign last_addr = AW'(depth - (AW + 1)'(1));

    assign o_cfg_ready    = cfg_ready_q;
    assign o_ctx_ready    = (state_q == ST_LOAD_CTX);
    assign o_qea_qbit_num = qbit_q;
    assign o_busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_done         = (state_q == ST_DONE);
    assign o_err          = err_q;
    assign o_exec_cycles  = cnt_q;

    qea_readout_buf #(
        .ADDR_W           (AW),
        .WORD_W           (STATE_W),
        .STATE_RD_LATENCY (STATE_RD_LATENCY)
    ) u_readout (
        .clk         (clk),
        .rst         (rst),
        .start_i     (rd_start),
        .last_addr_i (last_addr),
        .ena_o       (rd_ena),
        .addra_o     (rd_addr),
        .dout_i      (i_qea_state_dout),
        .res_valid_o (o_res_valid),
        .res_ready_i (i_res_ready),
        .res_data_o  (o_res_data),
        .res_last_o  (o_res_last),
        .done_o      (rd_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            qbit_q      <= '0;
            ins_q       <= '0;
            k_q         <= '0;
            a_q         <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qbit_q      <= qbit_d;
            ins_q       <= ins_d;
            k_q         <= k_d;
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            err_q       <= err_d;
            cfg_ready_q <= (state_d == ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        qbit_d  = qbit_q;
        ins_d   = ins_q;
        k_d     = k_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        err_d   = err_q;

        rd_start          = 1'b0;
        o_qea_start       = 1'b0;
        o_qea_ctx_en      = 1'b0;
        o_qea_ctx_wea     = 1'b0;
        o_qea_ctx_addr    = '0;
        o_qea_ctx_data    = '0;
        o_qea_state_ena   = 1'b0;
        o_qea_state_wea   = 1'b0;
        o_qea_state_addra = '0;
        o_qea_state_dina  = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_cfg_valid && cfg_ready_q) begin
                    if (cfg_ok) begin
                        qbit_d  = i_cfg_qbit_num;
                        ins_d   = i_cfg_ins_num;
                        err_d   = 1'b0;
                        k_d     = '0;
                        a_d     = '0;
                        state_d = (i_cfg_ins_num == '0) ? ST_INIT_STATE : ST_LOAD_CTX;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_CTX: begin
                if (i_ctx_valid) begin
                    o_qea_ctx_en   = 1'b1;
                    o_qea_ctx_wea  = 1'b1;
                    o_qea_ctx_addr = k_q[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    o_qea_ctx_data = i_ctx_data;
                    if (k_q == ins_q - KW'(1)) begin
                        state_d = ST_INIT_STATE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_INIT_STATE: begin
                o_qea_state_ena   = 1'b1;
                o_qea_state_wea   = 1'b1;
                o_qea_state_addra = a_q;
                if (a_q == '0) begin
                    o_qea_state_dina[STATE_W-1 -: DATA_WIDTH] = AMP;
                end
                if (a_q == last_addr) begin
                    a_d     = '0;
                    state_d = ST_START;
                end else begin
                    a_d = a_q + AW'(1);
                end
            end
            ST_START: begin
                o_qea_start = 1'b1;
                cnt_d       = '0;
                first_d     = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                first_d = 1'b0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
                // complete may still be high from the previous job in the
                // first RUN cycle, so it is only trusted from the second on.
                if (!first_q && i_qea_complete) begin
                    rd_start = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                o_qea_state_ena   = rd_ena;
                o_qea_state_addra = rd_addr;
                if (rd_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qea_host_sequencer.sv
module tb_qea_host_sequencer;

    logic         clk;
    logic         rst;
    logic         i_cfg_valid;
    logic         o_cfg_ready;
    logic [5:0]   i_cfg_qbit_num;
    logic [16:0]  i_cfg_ins_num;
    logic         i_ctx_valid;
    logic         o_ctx_ready;
    logic [63:0]  i_ctx_data;
    logic         o_qea_start;
    logic [5:0]   o_qea_qbit_num;
    logic         o_qea_ctx_en;
    logic         o_qea_ctx_wea;
    logic [15:0]  o_qea_ctx_addr;
    logic [63:0]  o_qea_ctx_data;
    logic         o_qea_state_ena;
    logic         o_qea_state_wea;
    logic [15:0]  o_qea_state_addra;
    logic [255:0] o_qea_state_dina;
    logic         i_qea_complete;
    logic [255:0] i_qea_state_dout;
    logic         o_res_valid;
    logic         i_res_ready;
    logic [255:0] o_res_data;
    logic         o_res_last;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [31:0]  o_exec_cycles;

    qea_host_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .i_cfg_valid       (i_cfg_valid),
        .o_cfg_ready       (o_cfg_ready),
        .i_cfg_qbit_num    (i_cfg_qbit_num),
        .i_cfg_ins_num     (i_cfg_ins_num),
        .i_ctx_valid       (i_ctx_valid),
        .o_ctx_ready       (o_ctx_ready),
        .i_ctx_data        (i_ctx_data),
        .o_qea_start       (o_qea_start),
        .o_qea_qbit_num    (o_qea_qbit_num),
        .o_qea_ctx_en      (o_qea_ctx_en),
        .o_qea_ctx_wea     (o_qea_ctx_wea),
        .o_qea_ctx_addr    (o_qea_ctx_addr),
        .o_qea_ctx_data    (o_qea_ctx_data),
        .o_qea_state_ena   (o_qea_state_ena),
        .o_qea_state_wea   (o_qea_state_wea),
        .o_qea_state_addra (o_qea_state_addra),
        .o_qea_state_dina  (o_qea_state_dina),
        .i_qea_complete    (i_qea_complete),
        .i_qea_state_dout  (i_qea_state_dout),
        .o_res_valid       (o_res_valid),
        .i_res_ready       (i_res_ready),
        .o_res_data        (o_res_data),
        .o_res_last        (o_res_last),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err),
        .o_exec_cycles     (o_exec_cycles)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model state for the current job
    int           cur_depth;
    int           run_len;
    int           ready_pct;
    logic [63:0]  exp_ctx[$];
    logic [255:0] exp_res [0:1023];
    logic [255:0] mem     [0:1023];

    // Observation logs
    int           cyc = 0;
    int unsigned  ctx_a_log[$];
    logic [63:0]  ctx_d_log[$];
    int unsigned  st_a_log[$];
    logic [255:0] st_d_log[$];
    logic [255:0] res_log[$];
    int           last_idx[$];
    int           ctx_bad_we;
    int           starts;
    int           done_cnt;
    int           done_cyc;
    int           last_acc_cyc;
    logic [31:0]  exec_at_done;
    logic         busy_at_done;
    int           stab_err = 0;
    int           tot_act = 0;
    bit           rd_pend = 0;
    int           rd_addr = 0;
    bit           prev_v = 0, prev_r = 0, prev_l = 0;
    logic [255:0] prev_d = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: all DUT outputs sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (o_qea_ctx_en) begin
            ctx_a_log.push_back(o_qea_ctx_addr);
            ctx_d_log.push_back(o_qea_ctx_data);
            if (!o_qea_ctx_wea) ctx_bad_we++;
            tot_act++;
        end
        if (o_qea_state_ena && o_qea_state_wea) begin
            st_a_log.push_back(o_qea_state_addra);
            st_d_log.push_back(o_qea_state_dina);
            mem[o_qea_state_addra & 16'h3ff] = o_qea_state_dina;
            tot_act++;
        end
        rd_pend = o_qea_state_ena && !o_qea_state_wea;
        rd_addr = int'(o_qea_state_addra) & 1023;
        if (o_qea_start) begin
            starts++;
            tot_act++;
        end
        if (prev_v && !prev_r) begin
            if (!o_res_valid || o_res_data !== prev_d || o_res_last !== prev_l) stab_err++;
        end
        if (o_res_valid && i_res_ready) begin
            res_log.push_back(o_res_data);
            if (o_res_last) last_idx.push_back(res_log.size() - 1);
            last_acc_cyc = cyc;
        end
        prev_v = o_res_valid;
        prev_r = i_res_ready;
        prev_d = o_res_data;
        prev_l = o_res_last;
        if (o_done) begin
            done_cnt++;
            done_cyc     = cyc;
            exec_at_done = o_exec_cycles;
            busy_at_done = o_busy;
        end
    end

    // State RAM read port: data valid one cycle after the read address.
    // Between reads the bus carries noise so a mistimed capture shows up.
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_pend) i_qea_state_dout = mem[rd_addr];
        else         i_qea_state_dout = rand256();
    end

    // QEA run model: the final state appears at start; complete stays high
    // through the first cycle after start (stale level from the last job),
    // drops, then rises run_len cycles after the start pulse.
    initial begin
        i_qea_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (o_qea_start) begin
                for (int a = 0; a < cur_depth; a++) mem[a] = exp_res[a];
                @(posedge clk); #1;
                @(posedge clk); #1;
                i_qea_complete = 1'b0;
                repeat (run_len - 2) @(posedge clk);
                #1 i_qea_complete = 1'b1;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1 i_res_ready = ($urandom_range(99) < ready_pct);
    end

    task automatic start_job(input int n, input int ins, input int gap);
        int  k;
        int  guard;
        bit  acc;
        cur_depth = 1 << (n - 2);
        exp_ctx.delete();
        for (int i = 0; i < ins; i++) exp_ctx.push_back({$urandom, $urandom});
        for (int a = 0; a < cur_depth; a++) exp_res[a] = rand256();
        ctx_a_log.delete(); ctx_d_log.delete();
        st_a_log.delete();  st_d_log.delete();
        res_log.delete();   last_idx.delete();
        ctx_bad_we = 0; starts = 0; done_cnt = 0; done_cyc = 0; last_acc_cyc = -100;

        guard = 0;
        while (!o_cfg_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("cfg_ready", o_cfg_ready, 1);
        i_cfg_valid    = 1'b1;
        i_cfg_qbit_num = 6'(n);
        i_cfg_ins_num  = 17'(ins);
        @(posedge clk); #1;
        i_cfg_valid = 1'b0;

        k = 0;
        guard = 0;
        while (k < ins && guard < 50000) begin
            i_ctx_valid = ($urandom_range(99) >= gap);
            i_ctx_data  = i_ctx_valid ? exp_ctx[k] : {$urandom, $urandom};
            @(negedge clk);
            acc = i_ctx_valid && o_ctx_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        i_ctx_valid = 1'b0;
        i_ctx_data  = {$urandom, $urandom};
        check_eq("ctx_fed", k, ins);
    endtask

    task automatic finish_job(input string tag);
        int           guard;
        int           mism;
        logic [255:0] exp_w;
        guard = 0;
        while (done_cnt == 0 && guard < 30000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq({tag, "_done_seen"}, (done_cnt != 0), 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq({tag, "_done_pulses"}, done_cnt, 1);

        mism = 0;
        for (int i = 0; i < ctx_a_log.size() && i < exp_ctx.size(); i++)
            if (ctx_a_log[i] != i || ctx_d_log[i] !== exp_ctx[i]) mism++;
        check_eq({tag, "_ctx_count"}, ctx_a_log.size(), exp_ctx.size());
        check_eq({tag, "_ctx_mism"}, mism + ctx_bad_we, 0);

        mism = 0;
        for (int i = 0; i < st_a_log.size() && i < cur_depth; i++) begin
            exp_w = (i == 0) ? (256'd1 << 254) : 256'd0;
            if (st_a_log[i] != i || st_d_log[i] !== exp_w) mism++;
        end
        check_eq({tag, "_init_count"}, st_a_log.size(), cur_depth);
        check_eq({tag, "_init_mism"}, mism, 0);
        if (st_d_log.size() > 0)
            check_eq({tag, "_init_word0"}, st_d_log[0], {32'h40000000, 224'd0});

        check_eq({tag, "_starts"}, starts, 1);
        check_eq({tag, "_exec_cycles"}, exec_at_done, run_len);

        mism = 0;
        for (int i = 0; i < res_log.size() && i < cur_depth; i++)
            if (res_log[i] !== exp_res[i]) mism++;
        check_eq({tag, "_res_count"}, res_log.size(), cur_depth);
        check_eq({tag, "_res_mism"}, mism, 0);
        check_eq({tag, "_last_count"}, last_idx.size(), 1);
        if (last_idx.size() > 0)
            check_eq({tag, "_last_idx"}, last_idx[0], cur_depth - 1);
        check_eq({tag, "_done_delay"}, done_cyc - last_acc_cyc, 1);
        check_eq({tag, "_busy_at_done"}, busy_at_done, 0);
        check_eq({tag, "_err"}, o_err, 0);
        check_eq({tag, "_stable"}, stab_err, 0);
    endtask

    task automatic run_job(input string tag, input int n, input int ins, input int gap,
                           input int rpct, input int t_run);
        ready_pct = rpct;
        run_len   = t_run;
        start_job(n, ins, gap);
        finish_job(tag);
    endtask

    task automatic bad_cfg(input string tag, input int n, input int ins);
        int a0;
        int guard;
        a0 = tot_act;
        guard = 0;
        while (!o_cfg_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        i_cfg_valid    = 1'b1;
        i_cfg_qbit_num = 6'(n);
        i_cfg_ins_num  = 17'(ins);
        @(posedge clk); #1;
        i_cfg_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq({tag, "_err"}, o_err, 1);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_activity"}, tot_act - a0, 0);
        check_eq({tag, "_ready"}, o_cfg_ready, 1);
    endtask

    logic outs_or;
    assign outs_or = |{o_cfg_ready, o_ctx_ready, o_qea_start, o_qea_qbit_num, o_qea_ctx_en,
                       o_qea_ctx_wea, o_qea_ctx_addr, o_qea_ctx_data, o_qea_state_ena,
                       o_qea_state_wea, o_qea_state_addra, o_qea_state_dina, o_res_valid,
                       o_res_data, o_res_last, o_busy, o_done, o_err, o_exec_cycles};

    initial begin
        int guard;
        int a0;
        rst              = 1'b1;
        i_cfg_valid      = 1'b0;
        i_cfg_qbit_num   = '0;
        i_cfg_ins_num    = '0;
        i_ctx_valid      = 1'b0;
        i_ctx_data       = '0;
        i_res_ready      = 1'b0;
        i_qea_state_dout = '0;
        ready_pct        = 100;
        run_len          = 10;
        cur_depth        = 1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", outs_or, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_cfg_ready", o_cfg_ready, 1);
        check_eq("idle_busy", o_busy, 0);

        run_job("jobA", 10, 501, 0, 100, 1000);
        run_job("jobB", 10, 300, 40, 50, 37);
        for (int j = 0; j < 3; j++)
            run_job("rand", 3 + $urandom_range(5), $urandom_range(80), $urandom_range(60),
                    20 + $urandom_range(80), 3 + $urandom_range(60));

        bad_cfg("cfg_n2", 2, 10);
        bad_cfg("cfg_n19", 19, 10);
        bad_cfg("cfg_ins_big", 5, 65537);
        run_job("n3_min", 3, 0, 0, 70, 5);
        run_job("ins_one", 4, 1, 0, 100, 3);

        // Reset while the state RAM is being initialised.
        ready_pct = 100;
        run_len   = 9;
        start_job(10, 5, 0);
        guard = 0;
        while (st_a_log.size() < 3 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("rst_mid_in_init", (st_a_log.size() >= 3), 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_outputs", outs_or, 0);
        a0 = tot_act;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_mid_no_activity", tot_act - a0, 0);
        check_eq("rst_mid_idle_ready", o_cfg_ready, 1);
        run_job("after_rst", 4, 20, 30, 60, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
